// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, ALU operation codes, sequencer state encoding
// and the control-word layout used by ControlUnit and the multicycle sequencer.
package mips_defs;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_RTYPE = 5'h00;
    localparam logic [OPC_W-1:0] OP_ADDI  = 5'h01;
    localparam logic [OPC_W-1:0] OP_BEQ   = 5'h04;
    localparam logic [OPC_W-1:0] OP_LW    = 5'h05;
    localparam logic [OPC_W-1:0] OP_SW    = 5'h0A;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    // Last wait-counter value before a memory access is declared dead (16 wait cycles).
    localparam logic [3:0] WAIT_LIMIT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_HALT_ERR = 3'd6
    } state_e;

    typedef struct packed {
        logic is_rtype;
        logic is_alui;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic legal;
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier; anything outside the supported set reports legal=0.
module op_class_decode
    import mips_defs::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_t        class_o
);

    always_comb begin
        class_o = '0;
        case (opcode_i)
            OP_RTYPE: begin class_o.is_rtype  = 1'b1; class_o.legal = 1'b1; end
            OP_ADDI:  begin class_o.is_alui   = 1'b1; class_o.legal = 1'b1; end
            OP_BEQ:   begin class_o.is_branch = 1'b1; class_o.legal = 1'b1; end
            OP_LW:    begin class_o.is_load   = 1'b1; class_o.legal = 1'b1; end
            OP_SW:    begin class_o.is_store  = 1'b1; class_o.legal = 1'b1; end
            default:  class_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_sequencer.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-wait
// timeout into a terminal error state. state_dbg exposes the registered state.
module mips_sequencer
    import mips_defs::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             MemWrite,
    output logic             ALUsrc,
    output logic             RegWrite,
    output logic [2:0]       ALUop,
    output logic             busy,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [2:0]       state_dbg
);

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             timeout_q, timeout_d;

    logic [OPC_W-1:0] op_sel;
    op_class_t        cls;
    ctrl_t            ctrl;
    logic             busy_c, done_c, illegal_c;
    state_e           retire_state;

    // In DECODE the opcode port is live; afterwards only the latched copy is used.
    assign op_sel = (state_q == ST_DECODE) ? opcode : opc_q;
    assign opc_d  = (state_q == ST_DECODE) ? opcode : opc_q;

    op_class_decode u_op_class_decode (
        .opcode_i (op_sel),
        .class_o  (cls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            opc_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            opc_q     <= opc_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        timeout_d    = timeout_q;
        ctrl         = CTRL_NONE;
        done_c       = 1'b0;
        illegal_c    = 1'b0;
        busy_c       = (state_q != ST_IDLE);
        retire_state = run ? ST_FETCH : ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_op   = ALUOP_ADD;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = ST_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_DECODE: begin
                if (!cls.legal) begin
                    illegal_c = 1'b1;
                    done_c    = 1'b1;
                    state_d   = retire_state;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.is_rtype) begin
                    ctrl.alu_op = ALUOP_FUNCT;
                    state_d     = ST_WB;
                end else if (cls.is_branch) begin
                    ctrl.alu_op   = ALUOP_SUB;
                    ctrl.branch   = 1'b1;
                    ctrl.pc_write = zero;
                    done_c        = 1'b1;
                    state_d       = retire_state;
                end else begin
                    ctrl.alu_src = 1'b1;
                    ctrl.alu_op  = ALUOP_ADD;
                    state_d      = cls.is_alui ? ST_WB : ST_MEM;
                end
            end
            ST_MEM: begin
                ctrl.mem_read  = cls.is_load;
                ctrl.mem_write = cls.is_store;
                if (mem_ready) begin
                    if (cls.is_store) begin
                        done_c  = 1'b1;
                        state_d = retire_state;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = cls.is_rtype;
                ctrl.mem_to_reg = cls.is_load;
                done_c          = 1'b1;
                state_d         = retire_state;
            end
            ST_HALT_ERR: begin
                state_d = ST_HALT_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet for as long as reset is held, not just after the edge.
        if (!rst_n) begin
            ctrl      = CTRL_NONE;
            done_c    = 1'b0;
            illegal_c = 1'b0;
            busy_c    = 1'b0;
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign Branch      = ctrl.branch;
    assign MemRead     = ctrl.mem_read;
    assign MemToReg    = ctrl.mem_to_reg;
    assign MemWrite    = ctrl.mem_write;
    assign ALUsrc      = ctrl.alu_src;
    assign RegWrite    = ctrl.reg_write;
    assign ALUop       = ctrl.alu_op;
    assign busy        = busy_c;
    assign instr_done  = done_c;
    assign illegal_op  = illegal_c;
    assign mem_timeout = timeout_q & rst_n;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_sequencer.sv
// Directed bench for mips_sequencer: per-cycle stimulus tables with hand-computed
// expected state and packed control vector.
module tb_mips_sequencer;

    localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3,
                           S_M = 3'd4, S_W = 3'd5, S_H = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [4:0] opcode = 5'h00;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, IRWrite, RegDst, Branch, MemRead, MemToReg, MemWrite;
    logic       ALUsrc, RegWrite, busy, instr_done, illegal_op, mem_timeout;
    logic [2:0] ALUop;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;

    // {PCWrite,IRWrite,RegDst,Branch,MemRead,MemToReg,MemWrite,ALUsrc,RegWrite,ALUop,busy,instr_done,illegal_op,mem_timeout}
    wire [15:0] obs = {PCWrite, IRWrite, RegDst, Branch, MemRead, MemToReg, MemWrite,
                       ALUsrc, RegWrite, ALUop, busy, instr_done, illegal_op, mem_timeout};

    mips_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .Branch      (Branch),
        .MemRead     (MemRead),
        .MemToReg    (MemToReg),
        .MemWrite    (MemWrite),
        .ALUsrc      (ALUsrc),
        .RegWrite    (RegWrite),
        .ALUop       (ALUop),
        .busy        (busy),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 5'h00;
        tick(); tick();
        #1;
        checks++;
        if (state_dbg !== S_I || obs !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state state=%0d vec=%h expected state=%0d vec=%h", state_dbg, obs, S_I, 16'h0000);
        end
        run = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (state_dbg !== S_I || obs !== 16'h0000) begin
            failures++;
            $display("FAIL reset_idle state=%0d vec=%h expected state=%0d vec=%h", state_dbg, obs, S_I, 16'h0000);
        end
    endtask

    task automatic test_rtype();
        logic       rn [6] = '{1, 1, 1, 1, 0, 0};
        logic [2:0] es [6] = '{S_I, S_F, S_D, S_E, S_W, S_I};
        logic [15:0] ev [6] = '{16'h0000, 16'hC908, 16'h0008, 16'h0028, 16'h208C, 16'h0000};
        int n_done = 0;
        opcode = 5'h00; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run = rn[i];
            #1;
            if (instr_done) n_done++;
            checks++;
            if (state_dbg !== es[i] || obs !== ev[i]) begin
                failures++;
                $display("FAIL rtype cyc%0d state=%0d vec=%h expected state=%0d vec=%h", i, state_dbg, obs, es[i], ev[i]);
            end
            tick();
        end
        checks++;
        if (n_done !== 1) begin
            failures++;
            $display("FAIL rtype_done_count got=%0d expected=1", n_done);
        end
    endtask

    task automatic test_lw_wait();
        logic       rn [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic       rd [9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
        logic [4:0] op [9] = '{5'h05, 5'h05, 5'h05, 5'h1F, 5'h1F, 5'h00, 5'h0A, 5'h04, 5'h05};
        logic [2:0] es [9] = '{S_I, S_F, S_D, S_E, S_M, S_M, S_M, S_W, S_I};
        logic [15:0] ev [9] = '{16'h0000, 16'hC908, 16'h0008, 16'h0108, 16'h0808,
                                16'h0808, 16'h0808, 16'h048C, 16'h0000};
        zero = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run = rn[i]; mem_ready = rd[i]; opcode = op[i];
            #1;
            checks++;
            if (state_dbg !== es[i] || obs !== ev[i]) begin
                failures++;
                $display("FAIL lw_wait cyc%0d state=%0d vec=%h expected state=%0d vec=%h", i, state_dbg, obs, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_beq_back_to_back();
        logic       rn [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic       zr [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic [2:0] es [8] = '{S_I, S_F, S_D, S_E, S_F, S_D, S_E, S_I};
        logic [15:0] ev [8] = '{16'h0000, 16'hC908, 16'h0008, 16'h901C,
                                16'hC908, 16'h0008, 16'h101C, 16'h0000};
        opcode = 5'h04; mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run = rn[i]; zero = zr[i];
            #1;
            checks++;
            if (state_dbg !== es[i] || obs !== ev[i]) begin
                failures++;
                $display("FAIL beq cyc%0d state=%0d vec=%h expected state=%0d vec=%h", i, state_dbg, obs, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic       rn [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic       rd [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
        logic [4:0] op [9] = '{5'h1F, 5'h1F, 5'h1F, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01};
        logic [2:0] es [9] = '{S_I, S_F, S_D, S_F, S_F, S_D, S_E, S_W, S_I};
        logic [15:0] ev [9] = '{16'h0000, 16'hC908, 16'h000E, 16'h0908, 16'hC908,
                                16'h0008, 16'h0108, 16'h008C, 16'h0000};
        zero = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run = rn[i]; mem_ready = rd[i]; opcode = op[i];
            #1;
            checks++;
            if (state_dbg !== es[i] || obs !== ev[i]) begin
                failures++;
                $display("FAIL illegal cyc%0d state=%0d vec=%h expected state=%0d vec=%h", i, state_dbg, obs, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_sw_run_drop();
        logic       rn [7] = '{1, 1, 1, 0, 0, 0, 0};
        logic       rd [7] = '{1, 1, 1, 1, 0, 1, 1};
        logic [2:0] es [7] = '{S_I, S_F, S_D, S_E, S_M, S_M, S_I};
        logic [15:0] ev [7] = '{16'h0000, 16'hC908, 16'h0008, 16'h0108,
                                16'h0208, 16'h020C, 16'h0000};
        opcode = 5'h0A; zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run = rn[i]; mem_ready = rd[i];
            #1;
            checks++;
            if (state_dbg !== es[i] || obs !== ev[i]) begin
                failures++;
                $display("FAIL sw_run_drop cyc%0d state=%0d vec=%h expected state=%0d vec=%h", i, state_dbg, obs, es[i], ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_instr();
        run = 1'b1; mem_ready = 1'b1; opcode = 5'h00;
        tick(); tick(); tick();
        checks++;
        if (state_dbg !== S_E) begin
            failures++;
            $display("FAIL midreset_reach_exec state=%0d expected=%0d", state_dbg, S_E);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_outputs vec=%h expected=%h", obs, 16'h0000);
        end
        tick();
        checks++;
        if (state_dbg !== S_I || obs !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_idle state=%0d vec=%h expected state=%0d vec=%h", state_dbg, obs, S_I, 16'h0000);
        end
        run = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        run = 1'b1; mem_ready = 1'b0; opcode = 5'h00;
        #1;
        checks++;
        if (state_dbg !== S_I || obs !== 16'h0000) begin
            failures++;
            $display("FAIL timeout_start state=%0d vec=%h expected state=%0d vec=%h", state_dbg, obs, S_I, 16'h0000);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (state_dbg !== S_F || obs !== 16'h0908) begin
                failures++;
                $display("FAIL timeout_wait%0d state=%0d vec=%h expected state=%0d vec=%h", i, state_dbg, obs, S_F, 16'h0908);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state_dbg !== S_H || obs !== 16'h0009) begin
                failures++;
                $display("FAIL timeout_halt%0d state=%0d vec=%h expected state=%0d vec=%h", i, state_dbg, obs, S_H, 16'h0009);
            end
            tick();
        end
        rst_n = 1'b0; run = 1'b0;
        tick();
        checks++;
        if (state_dbg !== S_I || obs !== 16'h0000 || mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear state=%0d vec=%h expected state=%0d vec=%h", state_dbg, obs, S_I, 16'h0000);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_stays_clear got=%0b expected=0", mem_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq_back_to_back();
        test_illegal();
        test_sw_run_drop();
        test_reset_mid_instr();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
